// File: rtl/gpr_wb_ctrl_pkg.sv
// Shared definitions for the GPR writeback controller: default widths,
// the pending-counter width, source identifiers and the counter update rule.
package gpr_wb_ctrl_pkg;

  localparam int GPR_DATA_WIDTH = 64;
  localparam int GPR_ADDR_WIDTH = 5;
  localparam int CNT_WIDTH      = 2;
  localparam int NUM_SRC        = 2;

  // Writeback sources; the value doubles as the bit index in a grant vector.
  typedef enum logic [0:0] {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  // Next value of one pending counter. A simultaneous reserve and retire
  // cancel out, the counter saturates at all-ones and never wraps below zero.
  function automatic logic [CNT_WIDTH-1:0] cnt_next(
    input logic [CNT_WIDTH-1:0] cur,
    input logic                 inc,
    input logic                 dec
  );
    logic [CNT_WIDTH-1:0] nxt;
    nxt = cur;
    if (inc && !dec && (cur != '1)) begin
      nxt = cur + CNT_WIDTH'(1);
    end else if (dec && !inc && (cur != '0)) begin
      nxt = cur - CNT_WIDTH'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gpr_wb_arb.sv
// Writeback source arbiter: picks at most one of ALU/LSU per cycle.
// Default build: fixed priority, LSU wins any contention, no state.
// With GPR_WB_RR_EN defined: round-robin, the source that lost the previous
// contention wins the next one; the pointer starts out favouring LSU.
module gpr_wb_arb
  import gpr_wb_ctrl_pkg::*;
(
`ifdef GPR_WB_RR_EN
  input  logic               clk,
  input  logic               rst,
`endif
  input  logic               alu_valid_i,
  input  logic               lsu_valid_i,
  output logic [NUM_SRC-1:0] grant_o
);

`ifdef GPR_WB_RR_EN
  src_e last_q, last_d;

  // Grant selection; on contention the pointer decides and is then advanced.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    grant_o = '0;
    last_d  = last_q;
    if (alu_valid_i && lsu_valid_i) begin
      if (last_q == SRC_LSU) begin
        grant_o[SRC_ALU] = 1'b1;
        last_d           = SRC_ALU;
      end else begin
        grant_o[SRC_LSU] = 1'b1;
        last_d           = SRC_LSU;
      end
    end else if (lsu_valid_i) begin
      grant_o[SRC_LSU] = 1'b1;
    end else if (alu_valid_i) begin
      grant_o[SRC_ALU] = 1'b1;
    end
  end

  // Remember the winner of the last contention; reset makes LSU win first.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (rst) begin
      last_q <= SRC_ALU;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed LSU-first priority.
  always_comb begin
    grant_o = '0;
    if (lsu_valid_i) begin
      grant_o[SRC_LSU] = 1'b1;
    end else if (alu_valid_i) begin
      grant_o[SRC_ALU] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/gpr_wb_ctrl.sv
// GPR writeback controller: arbitrates ALU and load results onto the single
// regfile write port (registered, one cycle after acceptance) and tracks
// outstanding writes per register with 2-bit saturating pending counters for
// issue-side hazard checks. Optional round-robin arbitration: GPR_WB_RR_EN.
module gpr_wb_ctrl
  import gpr_wb_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = GPR_DATA_WIDTH,
  parameter int ADDR_WIDTH = GPR_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] q_rs1,
  input  logic [ADDR_WIDTH-1:0] q_rs2,
  output logic                  q_busy1,
  output logic                  q_busy2,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = '1;

  logic [NUM_SRC-1:0]    grant;
  logic                  alu_acc, lsu_acc, wb_acc;
  logic [ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;

  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  logic [CNT_WIDTH-1:0]  cnt_q [NUM_REGS];
  logic [CNT_WIDTH-1:0]  cnt_d [NUM_REGS];
  logic                  inc_en, dec_en;

  gpr_wb_arb u_arb (
`ifdef GPR_WB_RR_EN
    .clk         (clk),
    .rst         (rst),
`endif
    .alu_valid_i (alu_valid),
    .lsu_valid_i (lsu_valid),
    .grant_o     (grant)
  );

  // Readies follow the grant (the regfile never stalls) and are held low in reset.
  always_comb begin
    alu_ready = grant[SRC_ALU] & ~rst;
    lsu_ready = grant[SRC_LSU] & ~rst;
    alu_acc   = alu_valid & alu_ready;
    lsu_acc   = lsu_valid & lsu_ready;
    wb_acc    = alu_acc | lsu_acc;
    wb_rd     = lsu_acc ? lsu_rd   : alu_rd;
    wb_data   = lsu_acc ? lsu_data : alu_data;
  end

  // Next write-port drive: pulse only for a non-zero destination, else hold.
  always_comb begin
    rf_wen_d   = wb_acc && (wb_rd != '0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (wb_acc) begin
      rf_waddr_d = wb_rd;
      rf_wdata_d = wb_data;
    end
  end

  // Registered regfile write port; reset also drops a same-cycle acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // Issue back-pressure when the destination's counter is full, and hazard flags.
  always_comb begin
    iss_ready = (cnt_q[iss_rd] != CNT_FULL);
    q_busy1   = (q_rs1 != '0) && (cnt_q[q_rs1] != '0);
    q_busy2   = (q_rs2 != '0) && (cnt_q[q_rs2] != '0);
  end

  // Pending-counter updates: reserve on accepted issue, retire on each write pulse.
  always_comb begin
    inc_en = iss_valid && iss_ready && (iss_rd != '0);
    dec_en = rf_wen_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_next(cnt_q[i],
                          inc_en && (iss_rd == ADDR_WIDTH'(i)),
                          dec_en && (rf_waddr_q == ADDR_WIDTH'(i)));
    end
  end

  // Pending-counter state.
  always_ff @(posedge clk) begin
    // NOTE: the counter array is flop-based and must start clean, so it is reset as a whole rather than left to a RAM macro.
    if (rst) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A write to a register with no outstanding reservation is a protocol error.
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    rf_wen_q |-> (cnt_q[rf_waddr_q] != '0));

endmodule
